// File: rtl/hdp_stream.sv
// hdp_stream
// ----------
// Streaming homomorphic decryption stage. It accepts 20-bit ciphertexts
// {a, b} over a valid/ready handshake and recovers the 8-bit plaintext
// pixel through a three-register pipeline:
//   S1 : capture a and b
//   S2 : phase = (b - a*SECRET_KEY) mod 1024
//   S3 : output register (pixel, noise flag, frame marker)
// Ciphertexts whose noise would corrupt the pixel are flagged, flagged
// transfers are counted, and the last pixel of each frame is marked.
//
// Parameters
//   SECRET_KEY   : shared secret s; must match the encryptor's key
//   DELTA_SHIFT  : log2 of the scaling factor delta (2 -> delta = 4)
//   FRAME_PIXELS : pixels per frame, 1..65535
//
// Ports
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   in_valid    : ciphertext present
//   in_ready    : pipeline can accept a ciphertext this cycle
//   ciphertext  : [19:10] = a, [9:0] = b
//   out_valid   : decrypted pixel present
//   out_ready   : consumer accepts the pixel
//   pixel_byte  : recovered plaintext pixel
//   noise_flag  : phase[1] set, pixel unreliable
//   frame_done  : marks the last pixel of a frame (qualified by out_valid)
//   noise_count : saturating count of flagged pixels transferred

module hdp_stream #(
  parameter int unsigned SECRET_KEY   = 7,
  parameter int unsigned DELTA_SHIFT  = 2,
  parameter int unsigned FRAME_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] ciphertext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  pixel_byte,
  output logic        noise_flag,
  output logic        frame_done,
  output logic [15:0] noise_count
);

  localparam logic [9:0]  KEY        = 10'(SECRET_KEY);
  localparam logic [15:0] LAST_PIXEL = 16'(FRAME_PIXELS - 1);

  logic        s1_valid;
  logic [9:0]  s1_a;
  logic [9:0]  s1_b;
  logic        s2_valid;
  logic [9:1]  s2_phase;

  logic        ready1;
  logic        ready2;
  logic        ready3;
  logic        transfer;

  logic [9:0]  prod;
  logic [9:1]  phase_next;
  logic [15:0] pixel_count;
  logic [15:0] pixel_count_next;

  // Each stage may load when it is empty or its occupant moves on this cycle.
  assign ready3   = !out_valid || out_ready;
  assign ready2   = !s2_valid || ready3;
  assign ready1   = !s1_valid || ready2;
  assign in_ready = ready1;
  assign transfer = out_valid && out_ready;

  // Only the low 10 bits of a*s survive the mod-1024 reduction, and those
  // are exact when the multiply is evaluated in a 10-bit context.
  assign prod = s1_a * KEY;

  // Phase bit 0 is always discarded, so only bits [9:1] are formed: the
  // difference of the upper bits minus the borrow out of bit 0.
  assign phase_next = s1_b[9:1] - prod[9:1] - {8'd0, ~s1_b[0] & prod[0]};

  // Counter value after this cycle's transfer. A pixel entering S3 either
  // finds S3 empty or displaces the pixel transferring right now, so this is
  // exactly the frame position of the incoming pixel.
  always_comb begin
    pixel_count_next = pixel_count;
    if (transfer) begin
      if (pixel_count == LAST_PIXEL)
        pixel_count_next = 16'd0;
      else
        pixel_count_next = pixel_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (ready1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= ciphertext[19:10];
        s1_b <= ciphertext[9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_phase <= '0;
    end else if (ready2) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_phase <= phase_next;
    end
  end

  // Output register only reloads when ready3, which keeps data stable
  // while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pixel_byte <= '0;
      noise_flag <= 1'b0;
      frame_done <= 1'b0;
    end else if (ready3) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        pixel_byte <= s2_phase[DELTA_SHIFT +: 8];
        noise_flag <= s2_phase[DELTA_SHIFT - 1];
        frame_done <= (pixel_count_next == LAST_PIXEL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_count <= '0;
      noise_count <= '0;
    end else begin
      pixel_count <= pixel_count_next;
      if (transfer && noise_flag && (noise_count != 16'hFFFF))
        noise_count <= noise_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hdp_stream.sv
// Testbench for hdp_stream. A queue-based reference model predicts, from the
// decryption arithmetic and the pipeline's occupancy rules, which pixels must
// emerge, when, and with which flags and counter values.

module tb_hdp_stream;

  localparam int KEY = 7;
  localparam int DS  = 2;
  localparam int FP  = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] ciphertext;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pixel_byte;
  logic        noise_flag;
  logic        frame_done;
  logic [15:0] noise_count;

  hdp_stream #(
    .SECRET_KEY  (KEY),
    .DELTA_SHIFT (DS),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_byte (pixel_byte),
    .noise_flag (noise_flag),
    .frame_done (frame_done),
    .noise_count(noise_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       nf;
    int         acc;
  } exp_t;

  exp_t expQ[$];
  int   cyc;
  int   idx;
  int   ncnt;
  int   acceptCount;
  int   checkCount;
  int   passCount;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    else
      passCount++;
  endtask

  // Decryption straight from the arithmetic: phase = (b - a*s) mod 1024,
  // pixel = floor(phase / delta), noise = bit 1 of phase.
  function automatic exp_t decode(input logic [9:0] a, input logic [9:0] b);
    exp_t e;
    int   ph;
    ph    = ((int'(b) - int'(a) * KEY) % 1024 + 1024) % 1024;
    e.pix = 8'(ph / (1 << DS));
    e.nf  = 1'((ph / 2) % 2);
    e.acc = cyc;
    return e;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the handshakes it predicts for this edge.
  task automatic applyStimulus(input logic iv, input logic [9:0] a, input logic [9:0] b,
                               input logic ordy, input logic r);
    logic expOv;
    logic expIr;
    exp_t e;
    in_valid   = iv;
    ciphertext = {a, b};
    out_ready  = ordy;
    rst        = r;
    #1;
    // A pixel reaches the output register three edges after its accept
    // unless it is queued behind others; the pipeline is full at 3 entries.
    expOv = (expQ.size() > 0) && ((cyc - expQ[0].acc) >= 3);
    expIr = (expQ.size() < 3) || ordy;
    checkOutput("in_ready", 32'(in_ready), 32'(expIr));
    checkOutput("out_valid", 32'(out_valid), 32'(expOv));
    checkOutput("noise_count", 32'(noise_count), 32'(ncnt));
    if (expOv) begin
      checkOutput("pixel_byte", 32'(pixel_byte), 32'(expQ[0].pix));
      checkOutput("noise_flag", 32'(noise_flag), 32'(expQ[0].nf));
      checkOutput("frame_done", 32'(frame_done), 32'(idx == FP - 1));
    end
    @(posedge clk);
    if (r) begin
      expQ.delete();
      idx  = 0;
      ncnt = 0;
    end else begin
      if (expOv && ordy) begin
        e = expQ.pop_front();
        if (e.nf && ncnt < 65535)
          ncnt++;
        idx = (idx == FP - 1) ? 0 : idx + 1;
      end
      if (iv && expIr) begin
        expQ.push_back(decode(a, b));
        acceptCount++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic pat[5];
    int   target;
    pat         = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cyc         = 0;
    idx         = 0;
    ncnt        = 0;
    acceptCount = 0;
    checkCount  = 0;
    passCount   = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    ciphertext  = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_pixel", 32'(pixel_byte), 32'd0);
    checkOutput("rst_noise_flag", 32'(noise_flag), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_noise_count", 32'(noise_count), 32'd0);

    // Directed decodes: nominal, modular wrap, zero, noisy.
    $display("[TB] directed decode vectors");
    applyStimulus(1'b1, 10'd5, 10'd436, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'd1000, 10'd852, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'd0, 10'd2, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);

    // Ten ciphertexts under the 1,0,0,1,0 backpressure pattern.
    $display("[TB] backpressure pattern");
    target = acceptCount + 10;
    for (int k = 0; k < 200 && acceptCount < target; k++)
      applyStimulus(1'b1, 10'($urandom), 10'($urandom), pat[k % 5], 1'b0);
    repeat (8) applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);

    // Nine pixels after a fresh reset with random stalls: marks on 4 and 8.
    $display("[TB] frame marking");
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b0, 1'b1);
    target = acceptCount + 9;
    for (int k = 0; k < 200 && acceptCount < target; k++)
      applyStimulus(1'b1, 10'($urandom), 10'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b0, 10'd0, 10'd0, 1'($urandom_range(0, 1)), 1'b0);
    repeat (6) applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);

    // Fully random traffic.
    $display("[TB] random traffic");
    for (int k = 0; k < 800; k++)
      applyStimulus(1'($urandom_range(0, 9) < 7), 10'($urandom), 10'($urandom),
                    1'($urandom_range(0, 9) < 6), 1'b0);

    // Reset while the pipeline is full and stalled.
    $display("[TB] reset mid-stall");
    repeat (5) applyStimulus(1'b1, 10'($urandom), 10'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 10'($urandom), 10'($urandom), 1'b0, 1'b1);
    repeat (6) applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);

    // Saturation of the noise counter.
    $display("[TB] noise counter saturation");
    repeat (65540) applyStimulus(1'b1, 10'd0, 10'd2, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);
    #1;
    checkOutput("noise_sat", 32'(noise_count), 32'hFFFF);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hdp_stream.md
# hdp_stream

Streaming homomorphic decryption stage that sits directly downstream of the pixel encryptor. It accepts 20-bit ciphertexts {a, b} over a valid/ready handshake and recovers the 8-bit plaintext pixel through a 3-stage pipeline. It flags ciphertexts whose noise exceeds the decodable margin and marks frame boundaries for the display/compare logic that follows.

## Interface
- SECRET_KEY, 7, shared secret s; must equal the encryptor's key
- DELTA_SHIFT, 2, log2 of scaling factor delta (delta = 4)
- FRAME_PIXELS, 64, pixels per frame; range 1..65535
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  ciphertext present
- in_ready  output  1  stage 1 can accept
- ciphertext  input  20  [19:10] = a (public key), [9:0] = b
- out_valid  output  1  decrypted pixel present
- out_ready  input  1  consumer accepts
- pixel_byte  output  8  recovered plaintext
- noise_flag  output  1  phase[1] set; noise ≥ 2, pixel unreliable
- frame_done  output  1  qualifies the last pixel of a frame
- noise_count  output  16  saturating count of flagged pixels transferred

## Operation
- All arithmetic is modulo 1024 (10-bit), matching the encryptor's truncated b.
- Stage 1 (S1): register a and b from ciphertext.
- Stage 2 (S2): phase = (b − a·SECRET_KEY) mod 1024. The product is computed at ≥13 bits; only bits [9:0] are kept. Subtraction wraps naturally in 10 bits.
- Stage 3 (S3, output register):
  - pixel_byte = phase[9:2] (floor by delta; error 0/1 discarded).
  - noise_flag = phase[1].
- Each stage carries a valid bit. Stage n loads when ready_n = !valid_n || ready_{n+1}, with ready_4 = out_ready. in_ready = ready_1 is combinational from out_ready through the valid bits. Bubbles collapse.
- A transfer occurs in any cycle with out_valid && out_ready.
- Pixel counter, 16-bit:
  - Increments on each transfer.
  - On the transfer where count == FRAME_PIXELS−1, frame_done is asserted with that pixel and the counter returns to 0.
  - frame_done is registered in S3 from the counter state, so it is valid only while out_valid is high.
- noise_count increments on each transfer with noise_flag = 1. It holds at 16'hFFFF.
- Output data (pixel_byte, noise_flag, frame_done) is stable while out_valid && !out_ready.

## Timing
- Reset (rst high at a clock edge) clears the following to 0: all stage valid bits, out_valid, pixel_byte, noise_flag, frame_done, pixel counter, noise_count.
  - in_ready reads 1 in the cycle after reset.
  - In-flight ciphertexts are discarded, including when reset arrives mid-stream or mid-stall.
- Latency: a ciphertext accepted at edge N appears with out_valid = 1 after edge N+2, i.e. 3 register stages. Throughput is 1 per cycle while out_ready = 1.
- Stall: with out_ready = 0, the pipeline fills.
  - in_ready falls only when all three valid bits are set.
  - Up to 3 ciphertexts are held; none are lost or duplicated.
- Simultaneous accept and transfer when the pipeline is full: allowed, because in_ready = 1 in the same cycle as out_ready = 1.
- A noise_flag transfer on the frame's last pixel updates both counters in the same cycle.

## Test plan
- Nominal decode: a=5, b=436 (pixel 100, e=1) -> pixel_byte=100, noise_flag=0, out_valid 3 cycles after accept.
- Modular wrap: a=1000, b=852 (pixel 255, e=0) -> pixel_byte=255, noise_flag=0. Also a=0, b=0 -> pixel_byte=0.
- Noise detection: a=0, b=2 -> pixel_byte=0, noise_flag=1, noise_count 0→1. Drive 65537 such transfers -> noise_count stays 16'hFFFF.
- Backpressure: stream 10 ciphertexts with out_ready toggling in the pattern 1,0,0,1,0 repeating -> all 10 pixels emerge in order, no drops or duplicates, and in_ready low exactly when 3 entries are held.
- Frame marking: FRAME_PIXELS=4, stream 9 pixels -> frame_done high only on transfers 4 and 8, and the counter continues correctly across the stall.
- Reset mid-operation: fill the pipeline with out_ready=0, assert rst for 1 cycle -> next cycle out_valid=0, counters=0, in_ready=1, and none of the old pixels ever appear.
